// File: rtl/mul_pkg.sv
// Shared widths, types and elaboration-time helpers for the 5x5 Wallace multiplier.
// The mask helpers track which bit columns of each tree row can be non-zero.
package mul_pkg;

    localparam int OPW = 5;
    localparam int PW  = 10;

    typedef logic [OPW-1:0] opnd_t;
    typedef logic [PW-1:0]  prod_t;

    // Occupied columns of partial-product row `row` (x AND y[row], shifted by row).
    function automatic prod_t pp_mask(input int row);
        prod_t m;
        m = '0;
        m[OPW-1:0] = '1;
        return m << row;
    endfunction

    function automatic prod_t csa_sum_mask(input prod_t a, input prod_t b, input prod_t c);
        return a | b | c;
    endfunction

    // A column emits a carry only when at least two of its inputs can be set.
    function automatic prod_t csa_carry_mask(input prod_t a, input prod_t b, input prod_t c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

endpackage

// File: rtl/wallace_mul_5x5_if.sv
// Operand/product bundle for wallace_mul_5x5: the master supplies operands,
// the slave (the multiplier) returns the registered product.
interface wallace_mul_5x5_if;
    import mul_pkg::*;

    logic  in_valid;
    opnd_t x;
    opnd_t y;
    prod_t p;
    logic  out_valid;

    modport master (output in_valid, output x, output y, input p, input out_valid);
    modport slave  (input in_valid, input x, input y, output p, output out_valid);

endinterface

// File: rtl/wallace_mul_5x5_csa.sv
// Adder leaves for the Wallace tree: a full adder and a mask-driven 3:2 row
// compressor that places full adders, half adders or wires per column.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module csa_row
    import mul_pkg::*;
#(
    parameter prod_t MASK_A = '0,
    parameter prod_t MASK_B = '0,
    parameter prod_t MASK_C = '0
) (
    input  prod_t a,
    input  prod_t b,
    input  prod_t c,
    output prod_t sum,
    output prod_t carry
);
    logic [PW-2:0] co;

    // Bits outside a row's mask are structurally zero, so XOR of all three is
    // the correct sum for every column that is not a full adder.
    for (genvar k = 0; k < PW-1; k++) begin : g_col
        localparam int CNT = int'(MASK_A[k]) + int'(MASK_B[k]) + int'(MASK_C[k]);
        if (CNT == 3) begin : g_fa
            full_adder u_fa (.a(a[k]), .b(b[k]), .cin(c[k]), .sum(sum[k]), .cout(co[k]));
        end else begin : g_ha
            assign sum[k] = a[k] ^ b[k] ^ c[k];
            if (CNT < 2) begin : g_none
                assign co[k] = 1'b0;
            end else if (!MASK_C[k]) begin : g_ab
                assign co[k] = a[k] & b[k];
            end else if (!MASK_B[k]) begin : g_ac
                assign co[k] = a[k] & c[k];
            end else begin : g_bc
                assign co[k] = b[k] & c[k];
            end
        end
    end

    // The top column never holds more than one bit in this tree.
    assign sum[PW-1] = a[PW-1] ^ b[PW-1] ^ c[PW-1];
    assign carry     = {co, 1'b0};

endmodule

// File: rtl/wallace_mul_5x5.sv
// Unsigned 5x5 multiplier: AND array, three Wallace 3:2 stages (5->4->3->2 rows),
// ripple-carry final adder and a single output register with a travelling valid.
module wallace_mul_5x5
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    wallace_mul_5x5_if.slave    bus
);
    localparam prod_t M0 = pp_mask(0);
    localparam prod_t M1 = pp_mask(1);
    localparam prod_t M2 = pp_mask(2);
    localparam prod_t M3 = pp_mask(3);
    localparam prod_t M4 = pp_mask(4);

    localparam prod_t M_S1 = csa_sum_mask(M0, M1, M2);
    localparam prod_t M_C1 = csa_carry_mask(M0, M1, M2);
    localparam prod_t M_S2 = csa_sum_mask(M_S1, M_C1, M3);
    localparam prod_t M_C2 = csa_carry_mask(M_S1, M_C1, M3);

    prod_t pp_row [OPW];
    prod_t s1, c1, s2, c2, s3, c3;
    logic [PW-1:0] rc;
    prod_t prod_p0;
    prod_t prod_p1;
    logic  vld_p1;

    // ---- stage p0: partial products, reduction tree, final adder ----
    for (genvar i = 0; i < OPW; i++) begin : g_pp
        assign pp_row[i] = prod_t'(bus.x & {OPW{bus.y[i]}}) << i;
    end

    csa_row #(.MASK_A(M0), .MASK_B(M1), .MASK_C(M2)) u_st1 (
        .a(pp_row[0]), .b(pp_row[1]), .c(pp_row[2]), .sum(s1), .carry(c1)
    );
    csa_row #(.MASK_A(M_S1), .MASK_B(M_C1), .MASK_C(M3)) u_st2 (
        .a(s1), .b(c1), .c(pp_row[3]), .sum(s2), .carry(c2)
    );
    csa_row #(.MASK_A(M_S2), .MASK_B(M_C2), .MASK_C(M4)) u_st3 (
        .a(s2), .b(c2), .c(pp_row[4]), .sum(s3), .carry(c3)
    );

    assign rc[0] = 1'b0;
    for (genvar k = 0; k < PW-1; k++) begin : g_rca
        full_adder u_fa (.a(s3[k]), .b(c3[k]), .cin(rc[k]), .sum(prod_p0[k]), .cout(rc[k+1]));
    end
    // Carry out of the top bit is always zero (31*31 < 1024), so it is not formed.
    assign prod_p0[PW-1] = s3[PW-1] ^ c3[PW-1] ^ rc[PW-1];

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            prod_p1 <= prod_p0;
            vld_p1  <= bus.in_valid;
        end
    end

    assign bus.p         = prod_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_wallace_mul_5x5.sv
// Directed and exhaustive checks of wallace_mul_5x5 against hand-computed products.
module tb_wallace_mul_5x5;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    wallace_mul_5x5_if bus ();

    wallace_mul_5x5 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply operands, then sample 1 time unit after the next rising edge.
    task automatic step(input logic v, input int a, input int b);
        bus.in_valid = v;
        bus.x        = opnd_t'(a);
        bus.y        = opnd_t'(b);
        @(posedge clk);
        #1;
    endtask

    int tx [11] = '{12, 15, 9, 10, 31, 30, 0, 7, 1, 31, 27};
    int ty [11] = '{12, 5, 5, 10, 31, 20, 27, 7, 31, 0, 19};
    int tp [11] = '{144, 75, 45, 100, 961, 600, 0, 49, 31, 0, 513};

    initial begin
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;

        // Run with 31*31 then assert reset asynchronously mid-cycle.
        step(1'b1, 31, 31);
        chk("pre_reset_p", 32'(bus.p), 961);
        chk("pre_reset_vld", 32'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_p", 32'(bus.p), 0);
        chk("async_rst_vld", 32'(bus.out_valid), 0);

        // Unknown operands while in reset must not reach the outputs.
        bus.x = 'x;
        bus.y = 'x;
        @(posedge clk);
        #1;
        chk("rst_x_p", 32'(bus.p), 0);
        chk("rst_x_vld", 32'(bus.out_valid), 0);

        rst_n = 1'b1;
        step(1'b0, 3, 3);
        chk("idle_vld", 32'(bus.out_valid), 0);
        chk("idle_p", 32'(bus.p), 9);
        step(1'b0, 0, 0);
        chk("idle_vld2", 32'(bus.out_valid), 0);

        // Directed products back to back.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tx[i], ty[i]);
            chk($sformatf("dir_p_%0dx%0d", tx[i], ty[i]), 32'(bus.p), 32'(tp[i]));
            chk($sformatf("dir_vld_%0d", i), 32'(bus.out_valid), 1);
        end

        // Valid gaps: out_valid follows in_valid one cycle later.
        step(1'b0, 5, 6);
        chk("gap_vld0", 32'(bus.out_valid), 0);
        chk("gap_p0", 32'(bus.p), 30);
        step(1'b1, 17, 3);
        chk("gap_vld1", 32'(bus.out_valid), 1);
        chk("gap_p1", 32'(bus.p), 51);

        // Reset between two valid operand pairs.
        step(1'b1, 13, 11);
        chk("mid_p_before", 32'(bus.p), 143);
        bus.x = 5'd6;
        bus.y = 5'd7;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_p", 32'(bus.p), 0);
        chk("mid_rst_vld", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        chk("mid_hold_p", 32'(bus.p), 0);
        rst_n = 1'b1;
        step(1'b0, 2, 2);
        chk("mid_rel_vld", 32'(bus.out_valid), 0);
        chk("mid_rel_p", 32'(bus.p), 4);
        step(1'b1, 6, 7);
        chk("mid_next_p", 32'(bus.p), 42);
        chk("mid_next_vld", 32'(bus.out_valid), 1);

        // Exhaustive sweep with a toggling valid pattern.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                logic v;
                v = logic'((a ^ b) & 1);
                step(v, a, b);
                chk($sformatf("exh_p_%0dx%0d", a, b), 32'(bus.p), 32'(a * b));
                chk($sformatf("exh_vld_%0dx%0d", a, b), 32'(bus.out_valid), 32'(v));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
